// File: rtl/regwr_arbiter.sv
// ============================================================================
// Module   : regwr_arbiter
// Purpose  : Arbitrates ALU/load writebacks onto the register file write port
//            and keeps a 32-entry pending scoreboard for RAW stall detection.
//            Optional macro REGWR_ARB_RR_EN enables round-robin arbitration;
//            without it the load path (M) has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regwr_arbiter (
  input  logic        Clk,
  input  logic        ResetL,
  input  logic        AValid,
  input  logic [4:0]  ARW,
  input  logic [63:0] AData,
  output logic        AReady,
  input  logic        MValid,
  input  logic [4:0]  MRW,
  input  logic [63:0] MData,
  output logic        MReady,
  output logic        RegWr,
  output logic [4:0]  RW,
  output logic [63:0] BusW,
  input  logic        ResvValid,
  input  logic [4:0]  ResvRW,
  output logic        ResvStall,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  output logic        BusyA,
  output logic        BusyB,
  output logic        WrUnresv
);

  localparam logic [4:0] c_ZERO_REG = 5'd31;

  logic [31:0] r_pending;
  logic [31:0] w_pendingNext;
  logic        r_wrUnresv;
  logic        r_regWr;
  logic [4:0]  r_rw;
  logic [63:0] r_busW;

  logic        w_grantA;
  logic        w_grantM;
  logic        w_accept;
  logic        w_acceptWrite;
  logic        w_resvSet;
  logic [4:0]  w_accRW;
  logic [63:0] w_accData;

`ifdef REGWR_ARB_RR_EN
  typedef enum logic {
    PTR_M = 1'b0,
    PTR_A = 1'b1
  } ptr_t;

  ptr_t r_ptr;
  ptr_t w_ptrNext;

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      r_ptr <= PTR_M;
    end else begin
      r_ptr <= w_ptrNext;
    end
  end

  // Only a contested grant hands priority to the requester that lost.
  always_comb begin
    w_ptrNext = r_ptr;
    if (AValid && MValid) begin
      w_ptrNext = w_grantM ? PTR_A : PTR_M;
    end
  end

  assign w_grantM = MValid && (!AValid || (r_ptr == PTR_M));
`else
  assign w_grantM = MValid;
`endif

  assign w_grantA      = AValid && !w_grantM;
  assign w_accept      = w_grantA || w_grantM;
  assign w_accRW       = w_grantM ? MRW : ARW;
  assign w_accData     = w_grantM ? MData : AData;
  assign w_acceptWrite = w_accept && (w_accRW != c_ZERO_REG);
  assign w_resvSet     = ResvValid && (ResvRW != c_ZERO_REG) && !r_pending[ResvRW];

  // Retire clears first so a same-edge reservation of that index wins.
  always_comb begin
    w_pendingNext = r_pending;
    if (r_regWr) begin
      w_pendingNext[r_rw] = 1'b0;
    end
    if (w_resvSet) begin
      w_pendingNext[ResvRW] = 1'b1;
    end
    w_pendingNext[31] = 1'b0;
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      r_pending  <= '0;
      r_wrUnresv <= 1'b0;
      r_regWr    <= 1'b0;
      r_rw       <= '0;
      r_busW     <= '0;
    end else begin
      r_pending <= w_pendingNext;
      r_regWr   <= w_acceptWrite;
      if (w_acceptWrite) begin
        r_rw   <= w_accRW;
        r_busW <= w_accData;
        if (!r_pending[w_accRW]) begin
          r_wrUnresv <= 1'b1;
        end
      end
    end
  end

  assign AReady    = w_grantA;
  assign MReady    = w_grantM;
  assign RegWr     = r_regWr;
  assign RW        = r_rw;
  assign BusW      = r_busW;
  assign ResvStall = ResvValid && (ResvRW != c_ZERO_REG) && r_pending[ResvRW];
  assign BusyA     = r_pending[RA];
  assign BusyB     = r_pending[RB];
  assign WrUnresv  = r_wrUnresv;

endmodule

`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
// ============================================================================
// Module   : tb_regwr_arbiter
// Purpose  : Self-checking bench for regwr_arbiter: directed scenarios plus
//            randomized traffic compared each cycle against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regwr_arbiter;

  logic        Clk;
  logic        ResetL;
  logic        AValid;
  logic [4:0]  ARW;
  logic [63:0] AData;
  logic        AReady;
  logic        MValid;
  logic [4:0]  MRW;
  logic [63:0] MData;
  logic        MReady;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        ResvValid;
  logic [4:0]  ResvRW;
  logic        ResvStall;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic        BusyA;
  logic        BusyB;
  logic        WrUnresv;

  int total = 0;
  int bad   = 0;

  regwr_arbiter dut (
    .Clk(Clk), .ResetL(ResetL),
    .AValid(AValid), .ARW(ARW), .AData(AData), .AReady(AReady),
    .MValid(MValid), .MRW(MRW), .MData(MData), .MReady(MReady),
    .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .ResvValid(ResvValid), .ResvRW(ResvRW), .ResvStall(ResvStall),
    .RA(RA), .RB(RB), .BusyA(BusyA), .BusyB(BusyB), .WrUnresv(WrUnresv)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who wins the port this cycle, from the arbitration rules.
  function automatic bit loadWins(input bit aV, input bit mV, input bit turnA);
`ifdef REGWR_ARB_RR_EN
    return mV && !(aV && turnA);
`else
    return mV;
`endif
  endfunction

  // Reference model state.
  bit          mPend [0:31];
  bit          mTurnA;
  bit          mWrUnresv;
  bit          mRegWr;
  logic [4:0]  mRW;
  logic [63:0] mBusW;

  always @(posedge Clk or negedge ResetL) begin : model
    bit          nxt [0:31];
    bit          winM;
    bit          winA;
    logic [4:0]  dst;
    if (!ResetL) begin
      for (int i = 0; i < 32; i++) mPend[i] <= 1'b0;
      mTurnA    <= 1'b0;
      mWrUnresv <= 1'b0;
      mRegWr    <= 1'b0;
      mRW       <= '0;
      mBusW     <= '0;
    end else begin
      for (int i = 0; i < 32; i++) nxt[i] = mPend[i];
      if (mRegWr) nxt[mRW] = 1'b0;
      if (ResvValid && ResvRW != 5'd31 && !mPend[ResvRW]) nxt[ResvRW] = 1'b1;
      for (int i = 0; i < 32; i++) mPend[i] <= nxt[i];

      winM = loadWins(AValid, MValid, mTurnA);
      winA = AValid && !winM;
      dst  = winM ? MRW : ARW;
      if ((winM || winA) && dst != 5'd31) begin
        mRegWr <= 1'b1;
        mRW    <= dst;
        mBusW  <= winM ? MData : AData;
        if (!mPend[dst]) mWrUnresv <= 1'b1;
      end else begin
        mRegWr <= 1'b0;
      end
      if (AValid && MValid) mTurnA <= winM;
    end
  end

  always @(negedge Clk) begin : compare
    bit eM;
    if (ResetL) begin
      eM = loadWins(AValid, MValid, mTurnA);
      cmp("MReady", {63'd0, MReady}, {63'd0, eM});
      cmp("AReady", {63'd0, AReady}, {63'd0, AValid && !eM});
      cmp("RegWr", {63'd0, RegWr}, {63'd0, mRegWr});
      if (mRegWr) begin
        cmp("RW", {59'd0, RW}, {59'd0, mRW});
        cmp("BusW", BusW, mBusW);
      end
      cmp("ResvStall", {63'd0, ResvStall},
          {63'd0, ResvValid && ResvRW != 5'd31 && mPend[ResvRW]});
      cmp("BusyA", {63'd0, BusyA}, {63'd0, mPend[RA]});
      cmp("BusyB", {63'd0, BusyB}, {63'd0, mPend[RB]});
      cmp("WrUnresv", {63'd0, WrUnresv}, {63'd0, mWrUnresv});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    ResetL = 1'b0;
    tick();
    ResetL = 1'b1;
  endtask

  function automatic logic [4:0] pickReg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  bit expM [0:3];
  bit aG;
  bit mG;

  initial begin
    ResetL = 1'b0;
    AValid = 0; ARW = 0; AData = 0;
    MValid = 0; MRW = 0; MData = 0;
    ResvValid = 0; ResvRW = 0; RA = 0; RB = 0;
    repeat (2) @(posedge Clk);
    #1;
    cmp("reset_regwr", {63'd0, RegWr}, 64'd0);
    cmp("reset_rw", {59'd0, RW}, 64'd0);
    cmp("reset_busw", BusW, 64'd0);
    cmp("reset_unresv", {63'd0, WrUnresv}, 64'd0);
    ResetL = 1'b1;

    // Single reserved write to X5.
    RA = 5; ResvValid = 1; ResvRW = 5;
    @(negedge Clk); cmp("sw_stall", {63'd0, ResvStall}, 64'd0);
    tick();
    ResvValid = 0; AValid = 1; ARW = 5; AData = 64'h1234;
    @(negedge Clk);
    cmp("sw_aready", {63'd0, AReady}, 64'd1);
    cmp("sw_busy_pre", {63'd0, BusyA}, 64'd1);
    tick();
    AValid = 0;
    @(negedge Clk);
    cmp("sw_regwr", {63'd0, RegWr}, 64'd1);
    cmp("sw_rw", {59'd0, RW}, 64'd5);
    cmp("sw_busw", BusW, 64'h1234);
    cmp("sw_busy_wr", {63'd0, BusyA}, 64'd1);
    tick();
    @(negedge Clk);
    cmp("sw_regwr_off", {63'd0, RegWr}, 64'd0);
    cmp("sw_busy_post", {63'd0, BusyA}, 64'd0);
    cmp("sw_unresv", {63'd0, WrUnresv}, 64'd0);
    tick();

    // Load to the zero register.
    MValid = 1; MRW = 31; MData = 64'hFFFF;
    @(negedge Clk); cmp("zr_mready", {63'd0, MReady}, 64'd1);
    tick();
    MValid = 0;
    @(negedge Clk);
    cmp("zr_regwr", {63'd0, RegWr}, 64'd0);
    cmp("zr_unresv", {63'd0, WrUnresv}, 64'd0);
    tick();

    // Double reservation of X7, then retire it.
    ResvValid = 1; ResvRW = 7; RA = 7;
    @(negedge Clk); cmp("rv_first", {63'd0, ResvStall}, 64'd0);
    tick();
    @(negedge Clk); cmp("rv_second", {63'd0, ResvStall}, 64'd1);
    tick();
    ResvValid = 0; MValid = 1; MRW = 7; MData = 64'h7;
    tick();
    MValid = 0;
    @(negedge Clk); cmp("rv_regwr", {63'd0, RegWr}, 64'd1);
    tick();
    @(negedge Clk); cmp("rv_busy_clr", {63'd0, BusyA}, 64'd0);

    // Reserve X7 on the edge its (unreserved) write retires.
    AValid = 1; ARW = 7; AData = 64'h77;
    tick();
    AValid = 0; ResvValid = 1; ResvRW = 7;
    @(negedge Clk);
    cmp("se_regwr", {63'd0, RegWr}, 64'd1);
    cmp("se_stall", {63'd0, ResvStall}, 64'd0);
    tick();
    ResvValid = 0;
    @(negedge Clk); cmp("se_busy", {63'd0, BusyA}, 64'd1);
    tick();
    @(negedge Clk); cmp("se_busy_hold", {63'd0, BusyA}, 64'd1);

    // Unreserved write to X9 sets the sticky flag.
    doReset();
    @(negedge Clk); cmp("x9_pre", {63'd0, WrUnresv}, 64'd0);
    AValid = 1; ARW = 9; AData = 64'h9;
    tick();
    AValid = 0;
    @(negedge Clk); cmp("x9_set", {63'd0, WrUnresv}, 64'd1);
    repeat (3) tick();
    @(negedge Clk); cmp("x9_sticky", {63'd0, WrUnresv}, 64'd1);

    // Contention from a fresh pointer.
    doReset();
`ifdef REGWR_ARB_RR_EN
    expM[0] = 1; expM[1] = 0; expM[2] = 1; expM[3] = 0;
`else
    expM[0] = 1; expM[1] = 1; expM[2] = 1; expM[3] = 1;
`endif
    AValid = 1; ARW = 10; AData = 64'hA;
    MValid = 1; MRW = 11; MData = 64'hB;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      cmp("ct_mready", {63'd0, MReady}, {63'd0, expM[i]});
      cmp("ct_aready", {63'd0, AReady}, {63'd0, !expM[i]});
      tick();
    end
    AValid = 0; MValid = 0;
    tick();

    // Asynchronous reset in the middle of a write and a grant to X3.
    doReset();
    ResvValid = 1; ResvRW = 3; RA = 3;
    tick();
    ResvValid = 0; AValid = 1; ARW = 3; AData = 64'h33;
    tick();
    @(negedge Clk);
    cmp("rs_regwr_pre", {63'd0, RegWr}, 64'd1);
    cmp("rs_aready", {63'd0, AReady}, 64'd1);
    #2 ResetL = 1'b0;
    #1;
    cmp("rs_regwr", {63'd0, RegWr}, 64'd0);
    cmp("rs_rw", {59'd0, RW}, 64'd0);
    cmp("rs_busw", BusW, 64'd0);
    cmp("rs_busy", {63'd0, BusyA}, 64'd0);
    AValid = 0;
    tick();
    ResetL = 1'b1;
    @(negedge Clk); cmp("rs_nowrite", {63'd0, RegWr}, 64'd0);
    tick();
    @(negedge Clk); cmp("rs_nowrite2", {63'd0, RegWr}, 64'd0);

    // Randomized traffic; a request is held until its Ready is seen.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge Clk);
      aG = AReady;
      mG = MReady;
      tick();
      if (!AValid || aG) begin
        AValid = 1'($urandom_range(0, 1));
        ARW    = pickReg();
        AData  = {$urandom, $urandom};
      end
      if (!MValid || mG) begin
        MValid = 1'($urandom_range(0, 1));
        MRW    = pickReg();
        MData  = {$urandom, $urandom};
      end
      ResvValid = 1'($urandom_range(0, 1));
      ResvRW    = pickReg();
      RA        = pickReg();
      RB        = pickReg();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
